// File: rtl/fp_minmax_reducer_pkg.sv
// Shared FPU definitions: ordering codes, reducer state encoding and float field helpers.
package fpu_pkg;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic fp_sign(input logic [31:0] v);
    return v[SIGN_BIT];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] v);
    return v[EXP_MSB:EXP_LSB];
  endfunction

  function automatic logic [22:0] fp_man(input logic [31:0] v);
    return v[MAN_MSB:0];
  endfunction

  function automatic logic fp_is_nan(input logic [31:0] v);
    return (fp_exp(v) == 8'hFF) && (fp_man(v) != 23'd0);
  endfunction

endpackage

// File: rtl/fp_minmax_reducer_if.sv
// Burst input / result output handshake bundle for fp_minmax_reducer.
// NAN_SEEN exists only when FP_MINMAX_NAN_FILTER_EN is defined.
interface fp_minmax_reducer_if #(
  parameter int CNT_W = 8
);
  logic             START;
  logic [CNT_W-1:0] COUNT;
  logic             IN_VALID;
  logic [31:0]      IN_DATA;
  logic             IN_READY;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [31:0]      MAX_VALUE;
  logic [31:0]      MIN_VALUE;
  logic [CNT_W-1:0] MAX_INDEX;
  logic [CNT_W-1:0] MIN_INDEX;
  logic             EMPTY;
  logic             BUSY;
`ifdef FP_MINMAX_NAN_FILTER_EN
  logic             NAN_SEEN;
`endif

  modport master (
    output START, COUNT, IN_VALID, IN_DATA, OUT_READY,
    input  IN_READY, OUT_VALID, MAX_VALUE, MIN_VALUE, MAX_INDEX, MIN_INDEX, EMPTY, BUSY
`ifdef FP_MINMAX_NAN_FILTER_EN
    , input NAN_SEEN
`endif
  );

  modport slave (
    input  START, COUNT, IN_VALID, IN_DATA, OUT_READY,
    output IN_READY, OUT_VALID, MAX_VALUE, MIN_VALUE, MAX_INDEX, MIN_INDEX, EMPTY, BUSY
`ifdef FP_MINMAX_NAN_FILTER_EN
    , output NAN_SEEN
`endif
  );

endinterface

// File: rtl/fp_minmax_reducer_compare.sv
// Combinational IEEE-754 single total-order compare: code is CMP_GT when a > b,
// CMP_LT when a < b, CMP_EQ only for identical bit patterns (+0 ranks above -0).
module fp_order_compare
  import fpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [1:0]  code_o
);

  logic a_mag_gt;

  assign a_mag_gt = {fp_exp(a_i), fp_man(a_i)} > {fp_exp(b_i), fp_man(b_i)};

  // NOTE: code_o gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    code_o = CMP_EQ;
    if (a_i != b_i) begin
      if (fp_sign(a_i) != fp_sign(b_i)) begin
        code_o = fp_sign(a_i) ? CMP_LT : CMP_GT;
      end else begin
        // Larger magnitude means larger value for positives, smaller for negatives.
        code_o = (a_mag_gt ^ fp_sign(a_i)) ? CMP_GT : CMP_LT;
      end
    end
  end

endmodule

// File: rtl/fp_minmax_reducer.sv
// Streaming running max/min (with indices) over a burst of single-precision floats.
// Optional NaN filtering and the NAN_SEEN flag are enabled by FP_MINMAX_NAN_FILTER_EN.
module fp_minmax_reducer
  import fpu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input logic                CLK,
  input logic                RESET,
  fp_minmax_reducer_if.slave bus
);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] idx_q;
  logic [31:0]      max_q;
  logic [31:0]      min_q;
  logic [CNT_W-1:0] max_idx_q;
  logic [CNT_W-1:0] min_idx_q;
  logic             empty_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic       accept;
  logic       last_elem;
  logic       in_nan;
  logic [1:0] max_code;
  logic [1:0] min_code;

  assign accept    = bus.IN_VALID & in_ready_q;
  assign last_elem = (idx_q == count_q - CNT_W'(1));

  fp_order_compare u_cmp_max (
    .a_i    (bus.IN_DATA),
    .b_i    (max_q),
    .code_o (max_code)
  );

  fp_order_compare u_cmp_min (
    .a_i    (bus.IN_DATA),
    .b_i    (min_q),
    .code_o (min_code)
  );

`ifdef FP_MINMAX_NAN_FILTER_EN
  logic nan_seen_q;

  assign in_nan = fp_is_nan(bus.IN_DATA);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      nan_seen_q <= 1'b0;
    end else if (state_q == ST_IDLE && bus.START) begin
      nan_seen_q <= 1'b0;
    end else if (accept && in_nan) begin
      nan_seen_q <= 1'b1;
    end
  end

  assign bus.NAN_SEEN = nan_seen_q;
`else
  assign in_nan = 1'b0;
`endif

  // NOTE: all state here is sequential, so every assignment is non-blocking (<=).
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      max_q       <= '0;
      min_q       <= '0;
      max_idx_q   <= '0;
      min_idx_q   <= '0;
      empty_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.START) begin
            count_q <= bus.COUNT;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            if (bus.COUNT == '0) begin
              state_q     <= ST_DONE;
              empty_q     <= 1'b1;
              out_valid_q <= 1'b1;
              max_q       <= '0;
              min_q       <= '0;
              max_idx_q   <= '0;
              min_idx_q   <= '0;
            end else begin
              state_q    <= ST_FIRST;
              in_ready_q <= 1'b1;
            end
          end
        end

        // FIRST waits for the element that seeds both extremes; a NaN only
        // parks the canonical NaN so an all-NaN burst still has a defined result.
        ST_FIRST: begin
          if (accept) begin
            idx_q <= idx_q + CNT_W'(1);
            if (in_nan) begin
              max_q     <= CANON_NAN;
              min_q     <= CANON_NAN;
              max_idx_q <= '0;
              min_idx_q <= '0;
            end else begin
              max_q     <= bus.IN_DATA;
              min_q     <= bus.IN_DATA;
              max_idx_q <= idx_q;
              min_idx_q <= idx_q;
            end
            if (last_elem) begin
              state_q     <= ST_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else if (!in_nan) begin
              state_q <= ST_ACCUM;
            end
          end
        end

        ST_ACCUM: begin
          if (accept) begin
            idx_q <= idx_q + CNT_W'(1);
            if (!in_nan) begin
              // Strict wins only, so ties keep the earliest index.
              if (max_code == CMP_GT) begin
                max_q     <= bus.IN_DATA;
                max_idx_q <= idx_q;
              end
              if (min_code == CMP_LT) begin
                min_q     <= bus.IN_DATA;
                min_idx_q <= idx_q;
              end
            end
            if (last_elem) begin
              state_q     <= ST_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          if (bus.OUT_READY) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            empty_q     <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.MAX_VALUE = max_q;
  assign bus.MIN_VALUE = min_q;
  assign bus.MAX_INDEX = max_idx_q;
  assign bus.MIN_INDEX = min_idx_q;
  assign bus.EMPTY     = empty_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_fp_minmax_reducer.sv
// Scoreboard bench for fp_minmax_reducer: directed and random bursts against a
// key-based ordering model; works with or without FP_MINMAX_NAN_FILTER_EN.
module tb_fp_minmax_reducer;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  fp_minmax_reducer_if #(.CNT_W(CNT_W)) bus ();

  fp_minmax_reducer #(.CNT_W(CNT_W)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] maxv;
    logic [31:0] minv;
    logic [7:0]  maxi;
    logic [7:0]  mini;
    logic        empty;
    logic        nan;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        last_exp;
  logic [31:0] stim[$];

  // Float bits mapped onto a signed integer line: -0 sits just below +0.
  function automatic longint fkey(input logic [31:0] v);
    longint mag;
    mag = longint'(v[30:0]);
    return v[31] ? -mag - 1 : mag;
  endfunction

  function automatic bit is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic exp_t model(input int n);
    exp_t e;
    bit   have;
    e = '{maxv: 32'd0, minv: 32'd0, maxi: 8'd0, mini: 8'd0, empty: (n == 0), nan: 1'b0};
    have = 0;
    for (int i = 0; i < n; i++) begin
`ifdef FP_MINMAX_NAN_FILTER_EN
      if (is_nan(stim[i])) begin
        e.nan = 1'b1;
        continue;
      end
`endif
      if (!have) begin
        have   = 1;
        e.maxv = stim[i];
        e.minv = stim[i];
        e.maxi = 8'(i);
        e.mini = 8'(i);
      end else begin
        if (fkey(stim[i]) > fkey(e.maxv)) begin
          e.maxv = stim[i];
          e.maxi = 8'(i);
        end
        if (fkey(stim[i]) < fkey(e.minv)) begin
          e.minv = stim[i];
          e.mini = 8'(i);
        end
      end
    end
    if (n > 0 && !have) begin
      e.maxv = 32'h7FC0_0000;
      e.minv = 32'h7FC0_0000;
    end
    return e;
  endfunction

  // Monitor: pops an expectation when a result appears, re-checks it every
  // cycle it is held, and retires it on the hand-off.
  exp_t cur;
  bit   have_cur = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.OUT_VALID) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", 32'(bus.OUT_VALID), 32'd0);
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1;
          end
        end
        if (have_cur) begin
          check("max_value", bus.MAX_VALUE, cur.maxv);
          check("min_value", bus.MIN_VALUE, cur.minv);
          check("max_index", 32'(bus.MAX_INDEX), 32'(cur.maxi));
          check("min_index", 32'(bus.MIN_INDEX), 32'(cur.mini));
          check("empty", 32'(bus.EMPTY), 32'(cur.empty));
          check("done_busy", 32'(bus.BUSY), 32'd1);
          check("done_in_ready", 32'(bus.IN_READY), 32'd0);
`ifdef FP_MINMAX_NAN_FILTER_EN
          check("nan_seen", 32'(bus.NAN_SEEN), 32'(cur.nan));
`endif
        end
        if (bus.OUT_READY) have_cur = 0;
      end else begin
        have_cur = 0;
      end
    end
  end

  // Runs one burst from stim[0..n-1]; always returns at #1 after a rising edge.
  task automatic run_burst(input int n, input bit stall, input int hold, input bit start_in_done);
    int s;
    int lat;
    bit got;
    last_exp = model(n);
    exp_q.push_back(last_exp);
    bus.START = 1'b1;
    bus.COUNT = CNT_W'(n);
    @(posedge clk);
    #1;
    s = cyc;
    bus.START = 1'b0;
    bus.COUNT = CNT_W'($urandom);
    for (int i = 0; i < n; i++) begin
      if (stall) begin
        for (int k = 0; k < 3 && $urandom_range(0, 2) == 0; k++) begin
          bus.IN_VALID = 1'b0;
          bus.IN_DATA  = $urandom;
          @(posedge clk);
          #1;
        end
      end
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = stim[i];
      got = 0;
      for (int t = 0; t < 50 && !got; t++) begin
        @(negedge clk);
        got = bus.IN_READY;
        @(posedge clk);
        #1;
      end
      check("in_ready_wait", 32'(got), 32'd1);
    end
    bus.IN_VALID = 1'b0;
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = bus.OUT_VALID;
      if (!got) begin
        @(posedge clk);
        #1;
      end
    end
    check("out_valid_wait", 32'(got), 32'd1);
    lat = cyc - s + 1;
    if (!stall && got) check("latency", 32'(lat), 32'(n + 1));
    @(posedge clk);
    #1;
    for (int h = 0; h < hold; h++) begin
      if (start_in_done && h == hold / 2) bus.START = 1'b1;
      bus.COUNT = CNT_W'(5);
      @(posedge clk);
      #1;
      bus.START = 1'b0;
    end
    bus.OUT_READY = 1'b1;
    bus.START     = start_in_done;
    @(posedge clk);
    #1;
    bus.OUT_READY = 1'b0;
    bus.START     = 1'b0;
    @(negedge clk);
    check("idle_out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("idle_busy", 32'(bus.BUSY), 32'd0);
    check("idle_empty", 32'(bus.EMPTY), 32'd0);
    check("idle_max_retained", bus.MAX_VALUE, last_exp.maxv);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] pool[8];
    pool = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
             32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h4000_0000};
    case ($urandom_range(0, 3))
      0: return pool[$urandom_range(0, 7)];
      1: return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom_range(0, 3))};
      default: return $urandom;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_max"}, bus.MAX_VALUE, 32'd0);
    check({tag, "_min"}, bus.MIN_VALUE, 32'd0);
    check({tag, "_max_idx"}, 32'(bus.MAX_INDEX), 32'd0);
    check({tag, "_min_idx"}, 32'(bus.MIN_INDEX), 32'd0);
    check({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.OUT_VALID), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.IN_READY), 32'd0);
    check({tag, "_empty"}, 32'(bus.EMPTY), 32'd0);
  endtask

  initial begin
    int n;
    bus.START     = 1'b0;
    bus.COUNT     = '0;
    bus.IN_VALID  = 1'b0;
    bus.IN_DATA   = '0;
    bus.OUT_READY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;

    stim = '{32'h3F80_0000, 32'hC000_0000, 32'h4060_0000, 32'h3F00_0000};
    run_burst(4, 0, 0, 0);
    stim = '{32'h4000_0000, 32'h4000_0000, 32'h8000_0000};
    run_burst(3, 0, 0, 0);
    stim = '{32'h8000_0000, 32'h0000_0000};
    run_burst(2, 0, 0, 0);
    stim.delete();
    run_burst(0, 0, 0, 0);
    stim = '{32'hC120_0000};
    run_burst(1, 0, 0, 0);

    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(rand_fp());
    run_burst(6, 1, 10, 1);

    // Reset after two of four elements: nothing may be reported.
    stim = '{32'h4120_0000, 32'hC120_0000, 32'h3F80_0000, 32'h0000_0000};
    bus.START = 1'b1;
    bus.COUNT = CNT_W'(4);
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = stim[i];
      @(posedge clk);
      #1;
    end
    bus.IN_VALID = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    run_burst(4, 0, 0, 0);

    stim = '{32'h7FC0_0000, 32'h3F80_0000, 32'hBF80_0000};
    run_burst(3, 0, 0, 0);
    stim = '{32'h7FC0_0000, 32'hFFC0_0001};
    run_burst(2, 0, 0, 0);

    for (int b = 0; b < 25; b++) begin
      n = $urandom_range(0, 12);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(rand_fp());
      run_burst(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    stim.delete();
    for (int i = 0; i < 255; i++) stim.push_back(rand_fp());
    run_burst(255, 0, 0, 0);

    repeat (2) @(posedge clk);
    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_minmax_reducer.md
Name: fp_minmax_reducer

Overview:
- Streaming consumer of the FPU ordering code. 00 = equal, 01 = a > b, 10 = a < b, 11 never produced.
- Accepts a burst of COUNT IEEE-754 single-precision values over a valid/ready handshake.
- Reports the running maximum and minimum, plus the index of each, through a held output handshake.
- Sits beside the FPU. Used by neuron/NoC logic for spike-threshold and winner-take-all selection.

Parameters:
- CNT_W, 8, width of COUNT and of the index outputs; a burst holds at most 2^CNT_W-1 elements.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-low reset.
- START  in  1  one-cycle pulse; latches COUNT and begins a burst; honoured only in IDLE.
- COUNT  in  CNT_W  number of elements in the burst.
- IN_VALID  in  1  IN_DATA is valid.
- IN_DATA  in  32  float operand.
- IN_READY  out  1  block accepts IN_DATA this cycle.
- OUT_VALID  out  1  result registers are valid.
- OUT_READY  in  1  consumer takes the result.
- MAX_VALUE  out  32  largest element.
- MIN_VALUE  out  32  smallest element.
- MAX_INDEX  out  CNT_W  position of MAX_VALUE within the burst.
- MIN_INDEX  out  CNT_W  position of MIN_VALUE within the burst.
- EMPTY  out  1  burst had COUNT = 0.
- BUSY  out  1  state is not IDLE.

Behaviour:
- States: IDLE, FIRST, ACCUM, DONE.
- Reset (RESET = 0 at a CLK edge) forces IDLE and clears every output and internal register to 0. This applies in any state, including mid-burst. A partial burst is discarded and never reported.
- IDLE:
  - IN_READY = 0.
  - On START: latch COUNT and clear the element counter idx to 0.
  - COUNT = 0 -> DONE with EMPTY = 1 and all value/index outputs 0.
  - COUNT > 0 -> FIRST.
- FIRST:
  - IN_READY = 1.
  - On accept (IN_VALID & IN_READY): load MAX_VALUE and MIN_VALUE with IN_DATA, set both indices to 0, set idx to 1.
  - If COUNT = 1 -> DONE; otherwise -> ACCUM.
- ACCUM:
  - IN_READY = 1.
  - On accept: compare IN_DATA against the MAX_VALUE register. Code 01 -> replace MAX_VALUE and set MAX_INDEX = idx.
  - In the same cycle, compare IN_DATA against the MIN_VALUE register. Code 10 -> replace MIN_VALUE and set MIN_INDEX = idx.
  - Only strict wins replace a stored value, so ties keep the earliest index.
  - idx increments by 1. When the accepted element is number COUNT-1 -> DONE.
- Throughput and latency:
  - One element per cycle while IN_VALID stays high.
  - OUT_VALID rises on the cycle after the last element is accepted.
  - Total latency from START is COUNT+1 cycles with no input stalls.
- DONE:
  - OUT_VALID = 1, IN_READY = 0.
  - Outputs hold stable while OUT_READY = 0.
  - On OUT_VALID & OUT_READY -> IDLE next cycle. OUT_VALID drops; value registers retain their contents; EMPTY clears.
- START is ignored in FIRST, ACCUM and DONE. START in the same cycle as a DONE hand-off is also ignored.
- Ordering rules:
  - Sign, then exponent, then mantissa, in magnitude order.
  - For negatives the exponent/mantissa order is inverted.
  - +0 (0x00000000) orders above -0 (0x80000000).
  - Identical bit patterns are equal.
- COUNT is latched at START. Later changes to the COUNT input have no effect on the running burst.
- The index counter never wraps, because COUNT ≤ 2^CNT_W-1.

Optional Feature:
- Macro: FP_MINMAX_NAN_FILTER_EN.
- Defined:
  - An element with exponent = 0xFF and mantissa ≠ 0 is accepted and counted but never stored.
  - Extra output NAN_SEEN (1 bit) sets on any NaN and clears on START or reset.
  - If the first element is a NaN, the next non-NaN element seeds MAX and MIN.
  - If every element is NaN, the value outputs are 0x7FC00000 and both indices are 0.
- Undefined: NaNs are ordered by raw bits using the rules above, and the NAN_SEEN port is absent.

Decomposition:
- Shared package fpu_pkg holds:
  - Ordering-code constants CMP_EQ = 2'b00, CMP_GT = 2'b01, CMP_LT = 2'b10.
  - The state encoding.
  - The float field slices: sign [31], exponent [30:23], mantissa [22:0].
  - The canonical NaN constant 0x7FC00000.
- One combinational sub-module, fp_order_compare, inputs a/b (32 bits) and outputs the 2-bit code.
  - Instantiated twice: IN_DATA vs MAX_VALUE and IN_DATA vs MIN_VALUE.
  - All sequencing stays in the top module.

Test Plan:
- Mixed burst: START, COUNT=4, data 0x3F800000, 0xC0000000, 0x40600000, 0x3F000000 back-to-back -> OUT_VALID at cycle 5; MAX 0x40600000 idx 2; MIN 0xC0000000 idx 1.
- Ties and zeros: COUNT=3, data 0x40000000, 0x40000000, 0x80000000 -> MAX 0x40000000 idx 0; MIN 0x80000000 idx 2. Separately, COUNT=2, data 0x80000000, 0x00000000 -> MAX idx 1, MIN idx 0.
- Empty and single: COUNT=0 -> next cycle OUT_VALID=1, EMPTY=1, outputs 0. COUNT=1 with data 0xC1200000 -> MAX = MIN = 0xC1200000, both indices 0.
- Handshake stress: IN_VALID toggled randomly, OUT_READY held low 10 cycles -> results unchanged and OUT_VALID held. START pulsed during DONE -> ignored. OUT_READY=1 -> IDLE.
- Reset mid-burst: RESET=0 after 2 of 4 elements -> all outputs 0, BUSY=0 on the next cycle. A new burst then runs correctly.
- NaN (macro defined): COUNT=3, data 0x7FC00000, 0x3F800000, 0xBF800000 -> NAN_SEEN=1; MAX 0x3F800000 idx 1; MIN 0xBF800000 idx 2.
